// File: rtl/tpum_pkg.sv
// rtl/tpum_pkg.sv - shared mode encodings and sequencer state type for the TPUM slice
package tpum_pkg;

   localparam logic [2:0] MODE_GEMM = 3'b001;
   localparam logic [2:0] MODE_BNN  = 3'b010;
   localparam logic [2:0] MODE_PUM  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_WT_A,
      ST_RD_B,
      ST_WT_B,
      ST_EXEC,
      ST_WR_C,
      ST_DONE
   } state_e;

   // Exactly one mode bit set; 000 and multi-bit encodings are rejected.
   function automatic logic mode_legal(input logic [2:0] m);
      return (m == MODE_GEMM) || (m == MODE_BNN) || (m == MODE_PUM);
   endfunction

endpackage

// File: rtl/tpum_seq_ctrl_if.sv
// rtl/tpum_seq_ctrl_if.sv - crossbar memory port between the sequencer and the PUM array
interface tpum_seq_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 1024
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   // Sequencer side issues requests; the crossbar grants and returns read data.
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/tpum_lane_alu.sv
// rtl/tpum_lane_alu.sv - combinational lane-wise GEMM/BNN/PUM combiner
module tpum_lane_alu
   import tpum_pkg::*;
#(
   parameter int DATA_W = 1024,
   parameter int LANE_W = 8
) (
   input  logic [2:0]        mode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   localparam int NLANES = DATA_W / LANE_W;

   // GEMM keeps only the low LANE_W bits of each per-lane unsigned product.
   always_comb begin
      y = '0;
      case (mode)
         MODE_GEMM: begin
            for (int k = 0; k < NLANES; k++) begin
               y[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] * b[k*LANE_W +: LANE_W];
            end
         end
         MODE_BNN: y = ~(a ^ b);
         MODE_PUM: y = a & b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/tpum_seq_ctrl.sv
// rtl/tpum_seq_ctrl.sv - streams A/B row pairs through the lane ALU and writes C rows
module tpum_seq_ctrl
   import tpum_pkg::*;
#(
   parameter int DATA_W = 1024,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        cfg_mode,
   input  logic [ADDR_W-1:0] cfg_base_a,
   input  logic [ADDR_W-1:0] cfg_base_b,
   input  logic [ADDR_W-1:0] cfg_base_c,
   input  logic [CNT_W-1:0]  cfg_count,
   tpum_seq_ctrl_if.master   mem,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  row_idx
);

   state_e            state_q, state_d;
   logic [2:0]        mode_q;
   logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  idx_q;
   logic [DATA_W-1:0] r1_q, r2_q, res_q;
   logic [DATA_W-1:0] alu_y;
   logic              err_q;
   logic              accept;
   logic              last_row;
   logic [ADDR_W-1:0] idx_off;

   assign accept   = (state_q == ST_IDLE) && start;
   // Row offset folded into the address width so base+i wraps modulo 2^ADDR_W.
   assign idx_off  = ADDR_W'(idx_q);
   assign last_row = (idx_q + CNT_W'(1)) == count_q;

   tpum_lane_alu #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_alu (
      .mode (mode_q),
      .a    (r1_q),
      .b    (r2_q),
      .y    (alu_y)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and memory port drive; address/data are pure functions of state so they hold through stalls.
   always_comb begin
      state_d       = state_q;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (!mode_legal(cfg_mode) || (cfg_count == '0)) state_d = ST_DONE;
               else                                            state_d = ST_RD_A;
            end
         end
         ST_RD_A: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = base_a_q + idx_off;
            if (mem.mem_gnt) state_d = ST_WT_A;
         end
         ST_WT_A: begin
            if (mem.mem_rvalid) state_d = ST_RD_B;
         end
         ST_RD_B: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = base_b_q + idx_off;
            if (mem.mem_gnt) state_d = ST_WT_B;
         end
         ST_WT_B: begin
            if (mem.mem_rvalid) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_WR_C;
         end
         ST_WR_C: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = base_c_q + idx_off;
            mem.mem_wdata = res_q;
            if (mem.mem_gnt) state_d = last_row ? ST_DONE : ST_RD_A;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Configuration snapshot taken only when a start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         base_c_q <= '0;
         count_q  <= '0;
      end else if (accept) begin
         mode_q   <= cfg_mode;
         base_a_q <= cfg_base_a;
         base_b_q <= cfg_base_b;
         base_c_q <= cfg_base_c;
         count_q  <= cfg_count;
      end
   end

   // Row index restarts at each accepted start and advances when a C write is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  idx_q <= '0;
      else if (accept)                             idx_q <= '0;
      else if ((state_q == ST_WR_C) && mem.mem_gnt) idx_q <= idx_q + CNT_W'(1);
   end

   // Operand capture; read data arriving in any other state is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q <= '0;
         r2_q <= '0;
      end else begin
         if ((state_q == ST_WT_A) && mem.mem_rvalid) r1_q <= mem.mem_rdata;
         if ((state_q == ST_WT_B) && mem.mem_rvalid) r2_q <= mem.mem_rdata;
      end
   end

   // Result register loads during the single EXEC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    res_q <= '0;
      else if (state_q == ST_EXEC)   res_q <= alu_y;
   end

   // Illegal-mode flag persists until the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (accept) err_q <= !mode_legal(cfg_mode);
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;
   assign row_idx = idx_q;

endmodule

// File: tb/tb_tpum_seq_ctrl.sv
// tb/tb_tpum_seq_ctrl.sv - directed self-checking bench for tpum_seq_ctrl
module tb_tpum_seq_ctrl;
   import tpum_pkg::*;

   localparam int DW = 32;
   localparam int LW = 8;
   localparam int AW = 8;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    cfg_mode = '0;
   logic [AW-1:0] cfg_base_a = '0;
   logic [AW-1:0] cfg_base_b = '0;
   logic [AW-1:0] cfg_base_c = '0;
   logic [CW-1:0] cfg_count = '0;
   logic          busy, done, err;
   logic [CW-1:0] row_idx;

   int n_assert = 0;
   int n_fail   = 0;

   tpum_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   tpum_seq_ctrl #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_mode   (cfg_mode),
      .cfg_base_a (cfg_base_a),
      .cfg_base_b (cfg_base_b),
      .cfg_base_c (cfg_base_c),
      .cfg_count  (cfg_count),
      .mem        (mif),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .row_idx    (row_idx)
   );

   always #5 clk = ~clk;

   // Crossbar memory model: decisions at negedge, response registered at posedge.
   logic [DW-1:0] mem [0:255];
   int            wait_left = 0;
   int            wait_nxt  = 0;
   bit            stall_en  = 1'b0;
   logic          rd_nxt = 1'b0, rv_q = 1'b0;
   logic [DW-1:0] rdata_nxt = '0, rdata_q = '0;
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   int            done_cnt = 0;
   int            req_cycles = 0;
   logic [AW-1:0] rd_addr_q [$];
   logic [CW-1:0] wr_idx_q [$];
   logic [63:0]   stall_obs_q [$];
   logic [63:0]   stall_exp_q [$];
   logic          stall_prev = 1'b0;
   logic [41:0]   prev_bus = '0;

   assign mif.mem_gnt    = mif.mem_req && (wait_left == 0);
   assign mif.mem_rvalid = rv_q;
   assign mif.mem_rdata  = rdata_q;

   always @(negedge clk) begin
      rd_nxt   = 1'b0;
      wait_nxt = wait_left;
      if (pl_en) mem[pl_addr] = pl_data;
      if (stall_prev && rst_n) begin
         stall_obs_q.push_back(64'({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}));
         stall_exp_q.push_back(64'({1'b1, prev_bus[40:0]}));
      end
      if (rst_n && mif.mem_req) begin
         req_cycles++;
         if (mif.mem_gnt) begin
            wait_nxt = stall_en ? int'($urandom_range(0, 5)) : 0;
            if (mif.mem_we) begin
               mem[mif.mem_addr] = mif.mem_wdata;
               wr_idx_q.push_back(row_idx);
            end else begin
               rd_nxt    = 1'b1;
               rdata_nxt = mem[mif.mem_addr];
               rd_addr_q.push_back(mif.mem_addr);
            end
         end else begin
            wait_nxt = wait_left - 1;
         end
      end
      stall_prev = rst_n && mif.mem_req && !mif.mem_gnt;
      prev_bus   = {1'b1, mif.mem_we, mif.mem_addr, mif.mem_wdata};
      if (done) done_cnt++;
   end

   always @(posedge clk) begin
      rv_q      <= rd_nxt;
      rdata_q   <= rdata_nxt;
      wait_left <= wait_nxt;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   function automatic logic [DW-1:0] gemm(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < DW / LW; k++) begin
         logic [15:0] p;
         p = a[k*LW +: LW] * b[k*LW +: LW];
         r[k*LW +: LW] = p[7:0];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pl(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(posedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] m, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c, input logic [CW-1:0] n);
      @(negedge clk);
      cfg_mode   = m;
      cfg_base_a = a;
      cfg_base_b = b;
      cfg_base_c = c;
      cfg_count  = n;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (busy) cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int            c0, r0, w0, s0, s_req, cyc;
      bit            ok;
      logic [DW-1:0] a_v [4];
      logic [DW-1:0] b_v [4];

      // Reset state
      #12;
      chk("reset_outs", 64'({busy, done, err, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, row_idx}), 64'd0);
      chk("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
      chk("reset_res", 64'(dut.res_q), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // GEMM single row, zero-wait memory
      pl(8'h10, 32'h02030405);
      pl(8'h20, 32'h10101010);
      pl(8'h30, 32'h0);
      r0 = rd_addr_q.size();
      c0 = done_cnt;
      do_start(MODE_GEMM, 8'h10, 8'h20, 8'h30, 10'd1);
      wait_done(cyc, ok);
      chk("gemm_timeout", 64'(ok), 64'd1);
      chk("gemm_latency", 64'(cyc), 64'd7);
      chk("gemm_err", 64'(err), 64'd0);
      @(negedge clk);
      #1;
      chk("gemm_c", 64'(mem[8'h30]), 64'h20304050);
      chk("gemm_rd_a", 64'(rd_addr_q[r0]), 64'h10);
      chk("gemm_rd_b", 64'(rd_addr_q[r0+1]), 64'h20);
      chk("gemm_done_pulses", 64'(done_cnt - c0), 64'd1);
      chk("gemm_idle", 64'(busy), 64'd0);

      // BNN three rows with A address wrap
      pl(8'hFE, 32'hF0F0AA55);
      pl(8'hFF, 32'h12345678);
      pl(8'h00, 32'hFFFF0000);
      pl(8'h40, 32'h0F0FAA55);
      pl(8'h41, 32'h12345678);
      pl(8'h42, 32'h00FF00FF);
      r0 = rd_addr_q.size();
      w0 = wr_idx_q.size();
      c0 = done_cnt;
      do_start(MODE_BNN, 8'hFE, 8'h40, 8'h50, 10'd3);
      wait_done(cyc, ok);
      chk("bnn_timeout", 64'(ok), 64'd1);
      @(negedge clk);
      #1;
      chk("bnn_c0", 64'(mem[8'h50]), 64'h0000FFFF);
      chk("bnn_c1", 64'(mem[8'h51]), 64'hFFFFFFFF);
      chk("bnn_c2", 64'(mem[8'h52]), 64'h00FFFF00);
      chk("bnn_rd_a0", 64'(rd_addr_q[r0]), 64'hFE);
      chk("bnn_rd_a1", 64'(rd_addr_q[r0+2]), 64'hFF);
      chk("bnn_rd_a2", 64'(rd_addr_q[r0+4]), 64'h00);
      for (int k = 0; k < 3; k++) chk("bnn_row_idx", 64'(wr_idx_q[w0+k]), 64'(k));
      chk("bnn_done_pulses", 64'(done_cnt - c0), 64'd1);
      chk("bnn_err", 64'(err), 64'd0);

      // Illegal mode, then count==0 in PUM mode
      s_req = req_cycles;
      do_start(3'b011, 8'h00, 8'h00, 8'h00, 10'd2);
      chk("ill_done", 64'(done), 64'd1);
      chk("ill_err", 64'(err), 64'd1);
      @(negedge clk);
      chk("ill_done_low", 64'(done), 64'd0);
      chk("ill_err_hold", 64'(err), 64'd1);
      chk("ill_busy", 64'(busy), 64'd0);
      do_start(MODE_PUM, 8'h00, 8'h00, 8'h00, 10'd0);
      chk("cnt0_done", 64'(done), 64'd1);
      chk("cnt0_err_clear", 64'(err), 64'd0);
      @(negedge clk);
      #1;
      chk("cnt0_idle", 64'(busy), 64'd0);
      chk("no_mem_traffic", 64'(req_cycles - s_req), 64'd0);

      // Reset during WT_B of row 1, then replay from row 0
      pl(8'h60, 32'hF0F00FF0);
      pl(8'h61, 32'h12345678);
      pl(8'h62, 32'hAAAAAAAA);
      pl(8'h68, 32'hFF00FF00);
      pl(8'h69, 32'h0F0F0F0F);
      pl(8'h6A, 32'hFFFF0000);
      r0 = rd_addr_q.size();
      do_start(MODE_PUM, 8'h60, 8'h68, 8'h70, 10'd3);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (rd_addr_q.size() >= r0 + 4) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_trigger", 64'(ok), 64'd1);
      @(posedge clk);
      #2;
      chk("in_wt_b", 64'(dut.state_q), 64'(ST_WT_B));
      chk("row1_before_rst", 64'(row_idx), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 64'({busy, done, err, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, row_idx}), 64'd0);
      chk("async_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r0 = rd_addr_q.size();
      do_start(MODE_PUM, 8'h60, 8'h68, 8'h70, 10'd3);
      chk("replay_row0", 64'(row_idx), 64'd0);
      chk("replay_req", 64'(mif.mem_req), 64'd1);
      chk("replay_addr", 64'(mif.mem_addr), 64'h60);
      wait_done(cyc, ok);
      chk("replay_timeout", 64'(ok), 64'd1);
      @(negedge clk);
      #1;
      chk("replay_first_rd", 64'(rd_addr_q[r0]), 64'h60);
      chk("pum_c0", 64'(mem[8'h70]), 64'hF0000F00);
      chk("pum_c1", 64'(mem[8'h71]), 64'h02040608);
      chk("pum_c2", 64'(mem[8'h72]), 64'hAAAA0000);

      // GEMM with random grant stalls and an ignored start while busy
      a_v[0] = 32'hFF100203;
      b_v[0] = 32'h021180FF;
      for (int k = 1; k < 4; k++) begin
         a_v[k] = $urandom;
         b_v[k] = $urandom;
      end
      for (int k = 0; k < 4; k++) begin
         pl(AW'(8'h80 + k), a_v[k]);
         pl(AW'(8'h90 + k), b_v[k]);
      end
      pl(8'hB0, 32'h0);
      stall_en = 1'b1;
      s0 = stall_obs_q.size();
      c0 = done_cnt;
      do_start(MODE_GEMM, 8'h80, 8'h90, 8'hA0, 10'd4);
      cfg_mode   = MODE_BNN;
      cfg_base_c = 8'hB0;
      cfg_count  = 10'd1;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, ok);
      chk("stall_timeout", 64'(ok), 64'd1);
      stall_en = 1'b0;
      @(negedge clk);
      #1;
      chk("stall_c0_direct", 64'(mem[8'hA0]), 64'hFE1000FD);
      for (int k = 0; k < 4; k++) chk("stall_c", 64'(mem[8'hA0 + k]), 64'(gemm(a_v[k], b_v[k])));
      chk("busy_start_ignored", 64'(done_cnt - c0), 64'd1);
      chk("b0_untouched", 64'(mem[8'hB0]), 64'd0);
      chk("stalls_seen", 64'(stall_obs_q.size() > s0), 64'd1);
      for (int k = s0; k < stall_obs_q.size(); k++) chk("stall_stable", stall_obs_q[k], stall_exp_q[k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
